reg_write_serializer: RTL
=========================

// Module: reg_write_serializer
// PURPOSE
//  Drains a 32-bit pending-write bitmask into a stream of encoded (writeReg, RegWrite) pairs.
//  It is the encoding end of the register-file write-select path: the output pair feeds the
//  5:32 write decoder directly.
//  Each accepted mask emits one write index per handshake, lowest index first. X31 (zero
//  register) is never emitted.
// PARAMETERS
//  N_REGS    32  width of in_mask / number of architectural registers
//  IDX_W     5   width of writeReg; log2(N_REGS)
//  ZERO_REG  31  index always stripped from the mask (hardwired-zero register)
// PORTS
//  clk       in   1       single clock, rising edge
//  reset     in   1       asynchronous, active-low reset
//  in_valid  in   1       in_mask valid
//  in_ready  out  1       block idle; mask accepted on in_valid & in_ready at posedge
//  in_mask   in   N_REGS  pending-write bitmask, bit i = register i
//  writeReg  out  IDX_W   encoded register index (lowest set pending bit)
//  RegWrite  out  1       output valid; writeReg meaningful only when 1
//  out_ready in   1       consumer takes writeReg on RegWrite & out_ready at posedge
//  done      out  1       one-cycle pulse: mask fully drained
// BEHAVIOUR
//  - Reset (async, reset==0): state=IDLE, pending=0, done=0 -> in_ready=1, RegWrite=0,
//    writeReg=0, immediately and without waiting for clk.
//  - Outputs are functions of registered state only; no combinational in->out path.
//  - FSM IDLE: in_ready=1, RegWrite=0.
//    - On in_valid: pending <= in_mask & ~(1<<ZERO_REG).
//    - If the stripped mask is nonzero: -> SCAN. Otherwise stay IDLE and done=1 next cycle.
//  - FSM SCAN: in_ready=0, RegWrite=1, writeReg = index of lowest set bit of pending.
//    - On out_ready: clear that bit.
//    - If it was the last set bit: -> IDLE and done=1 for exactly the next cycle.
//  - Latency: mask accepted at edge E -> first RegWrite=1 visible after E (cycle E+1).
//  - Throughput: one index per cycle while out_ready=1. A popcount-K mask occupies K
//    SCAN cycles.
//  - Backpressure: while RegWrite=1 & out_ready=0, writeReg and pending hold stable.
//  - in_valid in SCAN is ignored. No queueing; the source must hold the mask until in_ready.
//  - done and in_ready may both be 1 in the same cycle. A new mask may be accepted in the
//    done cycle.
//  - Encoding is a priority encoder over pending[N_REGS-1:0]; writeReg never equals ZERO_REG.
//  - Reset mid-SCAN discards the remaining pending bits; no done pulse is produced.
// CONFIGURATION
//  - WRITE_SER_ABORT_EN defined: adds input port `abort` (1 bit).
//    - abort=1 in SCAN at a posedge: pending <= 0, -> IDLE, no done pulse.
//    - An index handshaken in that same cycle still counts as delivered.
//    - abort in IDLE has no effect.
//  - WRITE_SER_ABORT_EN undefined: no abort port. A SCAN ends only by draining or by reset.
// TESTING
//  1. in_mask=0x0000_0005, out_ready=1
//     -> writeReg=0 then 2 on consecutive cycles (RegWrite=1); done pulses next cycle;
//        in_ready=1 again.
//  2. in_mask=0x8000_0000 or 0x0
//     -> RegWrite never 1; done=1 the cycle after acceptance; in_ready stays 1.
//  3. in_mask=0xFFFF_FFFF, out_ready=1
//     -> writeReg 0..30 in 31 consecutive cycles, never 31; done on cycle 32.
//  4. in_mask=0x0000_0100, out_ready=0 for 3 cycles
//     -> writeReg=8, RegWrite=1 held stable; in_ready=0; in_valid with 0x1 ignored.
//     -> After out_ready=1: done, and 0x1 is accepted only then.
//  5. in_mask=0x0000_00F0, reset=0 after 2 handshakes (4, 5)
//     -> RegWrite=0, in_ready=1 asynchronously; no done; indices 6, 7 never appear.
//  6. (WRITE_SER_ABORT_EN) in_mask=0x0000_0F00, abort=1 after index 8 taken
//     -> IDLE next cycle; done=0; 9..11 not emitted.

Source files
------------

// File: rtl/reg_write_serializer.sv
// Drains a pending-write mask into one register index per handshake, lowest first; optional abort via WRITE_SER_ABORT_EN.
// Latency: a mask accepted at edge E shows its first index from E+1; one index per cycle while out_ready=1.
// Backpressure: in_ready=0 while scanning; writeReg/pending hold while RegWrite=1 & out_ready=0.
module reg_write_serializer #(
    parameter int N_REGS   = 32,
    parameter int IDX_W    = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_REGS-1:0] in_mask,
    output logic [IDX_W-1:0]  writeReg,
    output logic              RegWrite,
    input  logic              out_ready,
`ifdef WRITE_SER_ABORT_EN
    input  logic              abort,
`endif
    output logic              done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    localparam logic [N_REGS-1:0] ZERO_MASK = {{(N_REGS-1){1'b0}}, 1'b1} << ZERO_REG;

    state_t              r_state;
    logic [N_REGS-1:0]   r_pending;
    logic [IDX_W-1:0]    r_write_reg;
    logic                r_in_ready;
    logic                r_reg_write;
    logic                r_done;

    logic [N_REGS-1:0]   w_stripped;
    logic [N_REGS-1:0]   w_pending_drop;
    logic [IDX_W-1:0]    w_stripped_idx;
    logic [IDX_W-1:0]    w_drop_idx;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_REGS-1:0] v);
        lowest_idx = '0;
        for (int i = N_REGS - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    // Clearing the lowest set bit: x & (x-1). The index register is loaded with the
    // encode of the *next* pending value so writeReg comes straight from a flop.
    always_comb begin
        w_stripped     = in_mask & ~ZERO_MASK;
        w_pending_drop = r_pending & (r_pending - N_REGS'(1));
        w_stripped_idx = lowest_idx(w_stripped);
        w_drop_idx     = lowest_idx(w_pending_drop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_write_reg <= '0;
            r_in_ready  <= 1'b1;
            r_reg_write <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_pending   <= w_stripped;
                        r_write_reg <= w_stripped_idx;
                        if (w_stripped != '0) begin
                            r_state     <= S_SCAN;
                            r_in_ready  <= 1'b0;
                            r_reg_write <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
`ifdef WRITE_SER_ABORT_EN
                    if (abort) begin
                        // An index handshaken this cycle is already delivered; just drop the rest.
                        r_state     <= S_IDLE;
                        r_pending   <= '0;
                        r_write_reg <= '0;
                        r_in_ready  <= 1'b1;
                        r_reg_write <= 1'b0;
                    end else
`endif
                    if (out_ready) begin
                        r_pending   <= w_pending_drop;
                        r_write_reg <= w_drop_idx;
                        if (w_pending_drop == '0) begin
                            r_state     <= S_IDLE;
                            r_in_ready  <= 1'b1;
                            r_reg_write <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_pending   <= '0;
                    r_write_reg <= '0;
                    r_in_ready  <= 1'b1;
                    r_reg_write <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign RegWrite = r_reg_write;
    assign writeReg = r_write_reg;
    assign done     = r_done;

endmodule
